ifmap_read_scheduler: RTL and testbench

//  Sequences the Ifmap BRAM address counter across a job of tiles and banks.
//  Per job: loops over banks [bank_first .. bank_first+bank_count-1]; per bank, num_tiles windows of tile_len words from base_addr.
//  For each window: one-cycle start pulse plus window/bank config to the counter, then waits for its done pulse.

---
 rtl/ifmap_read_scheduler.sv | 252 +++++++++++++++++++++++++
 tb/tb_ifmap_read_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_read_scheduler.sv
// ifmap_read_scheduler
//   Walks a job of banks x tiles and hands one address window at a time to the
//   Ifmap BRAM address counter. Each window is announced with a one-cycle
//   cnt_start and held on cnt_addr_start/cnt_addr_end/cnt_sel until the
//   counter answers with cnt_done. New windows are only launched while the
//   PE array signals pe_ready.
//
//   Optional build macro SCHED_PERF_CNT_EN adds perf_stall_cyc/perf_busy_cyc
//   cycle counters. Without it the ports and counter logic are absent.
module ifmap_read_scheduler #(
   parameter int NUM_BRAMS  = 16,
   parameter int ADDR_WIDTH = 9,
   parameter int TILE_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  job_valid,
   output logic                  job_ready,
   input  logic [ADDR_WIDTH-1:0] job_base_addr,
   input  logic [TILE_W-1:0]     job_tile_len,
   input  logic [TILE_W-1:0]     job_num_tiles,
   input  logic [3:0]            job_bank_first,
   input  logic [4:0]            job_bank_count,
   input  logic                  abort,
   input  logic                  pe_ready,
   output logic                  cnt_start,
   output logic [ADDR_WIDTH-1:0] cnt_addr_start,
   output logic [ADDR_WIDTH-1:0] cnt_addr_end,
   output logic [3:0]            cnt_sel,
   input  logic                  cnt_done,
   output logic [TILE_W-1:0]     tile_idx,
   output logic                  busy,
   output logic                  job_done,
   output logic                  job_err
`ifdef SCHED_PERF_CNT_EN
   ,
   output logic [31:0]           perf_stall_cyc,
   output logic [31:0]           perf_busy_cyc
`endif
);

   // Window arithmetic is done wide enough that base + tile*len never wraps.
   localparam int WIN_W = ADDR_WIDTH + TILE_W + 1;
   // The legality check multiplies two full TILE_W fields, so it gets more room.
   localparam int CHK_W = ADDR_WIDTH + 2 * TILE_W + 1;
   localparam logic [CHK_W-1:0] ADDR_SPACE = CHK_W'(2 ** ADDR_WIDTH);
   localparam logic [5:0]       BANK_LIMIT = 6'(NUM_BRAMS);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_NEXT  = 3'd3;
   localparam logic [2:0] S_FIN   = 3'd4;

   logic [2:0]            state;
   logic [2:0]            state_nxt;

   // Latched job fields and loop position
   logic [ADDR_WIDTH-1:0] base_q;
   logic [TILE_W-1:0]     len_q;
   logic [TILE_W-1:0]     ntiles_q;
   logic [TILE_W-1:0]     tile_q;
   logic [3:0]            bank_q;
   logic [4:0]            banks_rem_q;
   logic                  err_q;
   logic                  abort_q;

   logic                  job_accept;
   logic                  job_illegal;
   logic                  last_tile;
   logic                  last_bank;
   logic [TILE_W-1:0]     tile_nxt;
   logic [3:0]            bank_nxt;
   logic [ADDR_WIDTH-1:0] nxt_start;

   // First address of window 'tile' of a job starting at 'base'.
   function automatic logic [ADDR_WIDTH-1:0] window_start(
      input logic [ADDR_WIDTH-1:0] base,
      input logic [TILE_W-1:0]     tile,
      input logic [TILE_W-1:0]     len
   );
      logic [WIN_W-1:0] wide;
      wide = WIN_W'(base) + WIN_W'(tile) * WIN_W'(len);
      return ADDR_WIDTH'(wide);
   endfunction

   // Inclusive last address of a window of 'len' words starting at 'start'.
   function automatic logic [ADDR_WIDTH-1:0] window_end(
      input logic [ADDR_WIDTH-1:0] start,
      input logic [TILE_W-1:0]     len
   );
      logic [WIN_W-1:0] wide;
      wide = WIN_W'(start) + WIN_W'(len) - WIN_W'(1);
      return ADDR_WIDTH'(wide);
   endfunction

   // A job is rejected if any loop is empty, the bank range leaves the array,
   // or the last tile of a bank would run past the top of the BRAM.
   function automatic logic job_is_illegal(
      input logic [ADDR_WIDTH-1:0] base,
      input logic [TILE_W-1:0]     len,
      input logic [TILE_W-1:0]     tiles,
      input logic [3:0]            first,
      input logic [4:0]            count
   );
      logic [CHK_W-1:0] span;
      span = CHK_W'(base) + CHK_W'(tiles) * CHK_W'(len);
      return (len == '0) || (tiles == '0) || (count == '0) ||
             ({1'b0, count} > BANK_LIMIT) ||
             ((6'(first) + 6'(count)) > BANK_LIMIT) ||
             (span > ADDR_SPACE);
   endfunction

   assign job_accept  = (state == S_IDLE) && job_valid;
   assign job_illegal = job_is_illegal(job_base_addr, job_tile_len, job_num_tiles,
                                       job_bank_first, job_bank_count);

   // Position of the following window: next tile, or tile 0 of the next bank.
   assign last_tile = (tile_q == ntiles_q - TILE_W'(1));
   assign last_bank = (banks_rem_q == 5'd1);
   assign tile_nxt  = last_tile ? '0 : tile_q + TILE_W'(1);
   assign bank_nxt  = last_tile ? bank_q + 4'd1 : bank_q;
   assign nxt_start = window_start(base_q, tile_nxt, len_q);

   // Next-state selection; abort overrides everything outside IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (job_valid) begin
               state_nxt = job_illegal ? S_FIN : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (pe_ready) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_done) begin
               state_nxt = S_NEXT;
            end
         end
         S_NEXT: begin
            state_nxt = (last_tile && last_bank) ? S_FIN : S_ISSUE;
         end
         S_FIN: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (abort && (state != S_IDLE)) begin
         state_nxt = S_FIN;
      end
   end

   // State register, job latch, loop counters and held counter configuration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         base_q         <= '0;
         len_q          <= '0;
         ntiles_q       <= '0;
         tile_q         <= '0;
         bank_q         <= '0;
         banks_rem_q    <= '0;
         err_q          <= 1'b0;
         abort_q        <= 1'b0;
         cnt_addr_start <= '0;
         cnt_addr_end   <= '0;
         cnt_sel        <= '0;
      end else begin
         state <= state_nxt;
         if (abort && (state != S_IDLE)) begin
            abort_q <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (job_valid) begin
                  base_q      <= job_base_addr;
                  len_q       <= job_tile_len;
                  ntiles_q    <= job_num_tiles;
                  tile_q      <= '0;
                  bank_q      <= job_bank_first;
                  banks_rem_q <= job_bank_count;
                  err_q       <= job_illegal;
                  abort_q     <= 1'b0;
                  if (!job_illegal) begin
                     cnt_addr_start <= job_base_addr;
                     cnt_addr_end   <= window_end(job_base_addr, job_tile_len);
                     cnt_sel        <= job_bank_first;
                  end
               end
            end
            S_NEXT: begin
               if (!abort) begin
                  tile_q <= tile_nxt;
                  bank_q <= bank_nxt;
                  if (last_tile) begin
                     banks_rem_q <= banks_rem_q - 5'd1;
                  end
                  // The final window's settings stay visible after the job.
                  if (!(last_tile && last_bank)) begin
                     cnt_addr_start <= nxt_start;
                     cnt_addr_end   <= window_end(nxt_start, len_q);
                     cnt_sel        <= bank_nxt;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Handshake and status outputs decoded from the state.
   assign job_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign cnt_start = (state == S_ISSUE) && pe_ready && !abort;
   assign job_done  = (state == S_FIN) && !err_q && !abort_q && !abort;
   assign job_err   = (state == S_FIN) &&  err_q && !abort_q && !abort;
   assign tile_idx  = tile_q;

`ifdef SCHED_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == '1) ? value : value + 32'd1;
   endfunction

   // Stall and busy cycle counters, cleared on accept and frozen while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cyc <= '0;
         perf_busy_cyc  <= '0;
      end else if (job_accept) begin
         perf_stall_cyc <= '0;
         perf_busy_cyc  <= '0;
      end else begin
         if ((state == S_ISSUE) && !pe_ready) begin
            perf_stall_cyc <= sat_inc(perf_stall_cyc);
         end
         if (busy) begin
            perf_busy_cyc <= sat_inc(perf_busy_cyc);
         end
      end
   end
`else
   // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ifmap_read_scheduler.sv
// Directed bench for ifmap_read_scheduler with a behavioural address counter
// that answers each cnt_start with cnt_done after tile_len cycles.
module tb_ifmap_read_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       job_valid;
   logic       job_ready;
   logic [8:0] job_base_addr;
   logic [7:0] job_tile_len;
   logic [7:0] job_num_tiles;
   logic [3:0] job_bank_first;
   logic [4:0] job_bank_count;
   logic       abort;
   logic       pe_ready;
   logic       cnt_start;
   logic [8:0] cnt_addr_start;
   logic [8:0] cnt_addr_end;
   logic [3:0] cnt_sel;
   logic       cnt_done;
   logic [7:0] tile_idx;
   logic       busy;
   logic       job_done;
   logic       job_err;
`ifdef SCHED_PERF_CNT_EN
   logic [31:0] perf_stall_cyc;
   logic [31:0] perf_busy_cyc;
`endif

   logic model_done = 1'b0;
   logic man_done   = 1'b0;
   bit   model_en   = 1'b1;
   assign cnt_done = model_done | man_done;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   logic [21:0] win_q[$];
   logic [21:0] held = '0;
   int starts    = 0;
   int dones     = 0;
   int errs      = 0;
   int bb_viol   = 0;
   int hold_viol = 0;
   int m_busy    = 0;
   logic prev_start = 1'b0;

   always #5 clk = ~clk;

   ifmap_read_scheduler dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .job_valid      (job_valid),
      .job_ready      (job_ready),
      .job_base_addr  (job_base_addr),
      .job_tile_len   (job_tile_len),
      .job_num_tiles  (job_num_tiles),
      .job_bank_first (job_bank_first),
      .job_bank_count (job_bank_count),
      .abort          (abort),
      .pe_ready       (pe_ready),
      .cnt_start      (cnt_start),
      .cnt_addr_start (cnt_addr_start),
      .cnt_addr_end   (cnt_addr_end),
      .cnt_sel        (cnt_sel),
      .cnt_done       (cnt_done),
      .tile_idx       (tile_idx),
      .busy           (busy),
      .job_done       (job_done),
      .job_err        (job_err)
`ifdef SCHED_PERF_CNT_EN
      ,
      .perf_stall_cyc (perf_stall_cyc),
      .perf_busy_cyc  (perf_busy_cyc)
`endif
   );

   // Counter model and event monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_busy     = 0;
         model_done = 1'b0;
         prev_start = 1'b0;
      end else begin
         if (model_done) model_done = 1'b0;
         if (m_busy > 0) begin
            if ({cnt_sel, cnt_addr_start, cnt_addr_end} !== held) hold_viol++;
            m_busy--;
            if (m_busy == 0) model_done = 1'b1;
         end
         if (cnt_start) begin
            starts++;
            win_q.push_back({cnt_sel, cnt_addr_start, cnt_addr_end});
            if (prev_start) bb_viol++;
            if (model_en) begin
               held   = {cnt_sel, cnt_addr_start, cnt_addr_end};
               m_busy = int'(cnt_addr_end) - int'(cnt_addr_start) + 1;
            end
         end
         prev_start = cnt_start;
         if (job_done) dones++;
         if (job_err) errs++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_job(input int base, input int len, input int tiles,
                            input int first, input int count);
      job_base_addr  = 9'(base);
      job_tile_len   = 8'(len);
      job_num_tiles  = 8'(tiles);
      job_bank_first = 4'(first);
      job_bank_count = 5'(count);
      job_valid      = 1'b1;
      tick();
      job_valid      = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int ev0, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (dones + errs != ev0) break;
         tick();
      end
      check(tag, 32'(dones + errs - ev0), 32'd1);
   endtask

   task automatic chk_win(input string tag, input int idx, input int sel, input int s, input int e);
      logic [21:0] exp_w;
      logic [21:0] obs_w;
      exp_w = {4'(sel), 9'(s), 9'(e)};
      obs_w = (idx < win_q.size()) ? win_q[idx] : 22'h3fffff;
      check(tag, 32'(obs_w), 32'(exp_w));
   endtask

   task automatic chk_illegal(input string tag, input int base, input int len, input int tiles,
                              input int first, input int count);
      int ev0, s0, d0, e0;
      ev0 = dones + errs; s0 = starts; d0 = dones; e0 = errs;
      issue_job(base, len, tiles, first, count);
      wait_end({tag, "_end"}, ev0, 10);
      tick();
      check({tag, "_err"}, 32'(errs - e0), 32'd1);
      check({tag, "_nodone"}, 32'(dones - d0), 32'd0);
      check({tag, "_nostart"}, 32'(starts - s0), 32'd0);
   endtask

   initial begin
      int ev0, s0, d0, e0;
      rst_n = 1'b0; job_valid = 1'b0; abort = 1'b0; pe_ready = 1'b1;
      job_base_addr = '0; job_tile_len = '0; job_num_tiles = '0;
      job_bank_first = '0; job_bank_count = '0;
      #12;
      check("rst_ready", 32'(job_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_start", 32'(cnt_start), 32'd0);
      check("rst_cfg", 32'({cnt_sel, cnt_addr_start, cnt_addr_end}), 32'd0);
      check("rst_tile", 32'(tile_idx), 32'd0);
      check("rst_pulses", 32'({job_done, job_err}), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // T1: single bank, three tiles of four words
      win_q.delete(); ev0 = dones + errs; d0 = dones; e0 = errs;
      issue_job(0, 4, 3, 2, 1);
      check("t1_start_lat", 32'(cnt_start), 32'd1);
      check("t1_first_cfg", 32'({cnt_sel, cnt_addr_start, cnt_addr_end}), 32'({4'd2, 9'd0, 9'd3}));
      check("t1_busy", 32'(busy), 32'd1);
      wait_end("t1_end", ev0, 200);
      check("t1_nwin", 32'(win_q.size()), 32'd3);
      chk_win("t1_w0", 0, 2, 0, 3);
      chk_win("t1_w1", 1, 2, 4, 7);
      chk_win("t1_w2", 2, 2, 8, 11);
      check("t1_done", 32'(dones - d0), 32'd1);
      check("t1_noerr", 32'(errs - e0), 32'd0);
      check("t1_idle", 32'(job_ready), 32'd1);
      check("t1_tile0", 32'(tile_idx), 32'd0);

      // T2: two banks ending at the top bank
      win_q.delete(); ev0 = dones + errs;
      issue_job(100, 8, 2, 14, 2);
      wait_end("t2_end", ev0, 300);
      check("t2_nwin", 32'(win_q.size()), 32'd4);
      chk_win("t2_w0", 0, 14, 100, 107);
      chk_win("t2_w1", 1, 14, 108, 115);
      chk_win("t2_w2", 2, 15, 100, 107);
      chk_win("t2_w3", 3, 15, 108, 115);

      // T3: downstream stall for five cycles in ISSUE
      win_q.delete(); ev0 = dones + errs; s0 = starts;
      pe_ready = 1'b0;
      issue_job(0, 2, 1, 0, 1);
      for (int i = 0; i < 5; i++) begin
         check("t3_stall_nostart", 32'(cnt_start), 32'd0);
         tick();
      end
      check("t3_no_window", 32'(starts - s0), 32'd0);
      pe_ready = 1'b1;
      #1;
      check("t3_release", 32'(cnt_start), 32'd1);
      wait_end("t3_end", ev0, 100);
      chk_win("t3_w0", 0, 0, 0, 1);
`ifdef SCHED_PERF_CNT_EN
      check("t3_perf_stall", perf_stall_cyc, 32'd5);
      check("t3_perf_busy", perf_busy_cyc, 32'd10);
`endif

      // T4: rejected jobs, plus a job that exactly fills the address space
      chk_illegal("t4_range", 500, 8, 2, 0, 1);
      chk_illegal("t4_count0", 0, 4, 1, 0, 0);
      chk_illegal("t4_bankrng", 0, 4, 1, 15, 2);
      chk_illegal("t4_len0", 0, 0, 1, 0, 1);
      win_q.delete(); ev0 = dones + errs; d0 = dones;
      issue_job(496, 8, 2, 15, 1);
      wait_end("t4_edge_end", ev0, 100);
      check("t4_edge_done", 32'(dones - d0), 32'd1);
      chk_win("t4_edge_w0", 0, 15, 496, 503);
      chk_win("t4_edge_w1", 1, 15, 504, 511);

      // T5: abort in WAIT coinciding with cnt_done
      model_en = 1'b0; s0 = starts; d0 = dones; e0 = errs;
      issue_job(0, 4, 3, 0, 1);
      check("t5_start", 32'(cnt_start), 32'd1);
      tick();
      check("t5_wait_nostart", 32'(cnt_start), 32'd0);
      abort = 1'b1; man_done = 1'b1;
      tick();
      abort = 1'b0; man_done = 1'b0;
      check("t5_fin_nodone", 32'(job_done), 32'd0);
      check("t5_fin_notready", 32'(job_ready), 32'd0);
      tick();
      check("t5_ready", 32'(job_ready), 32'd1);
      repeat (4) tick();
      check("t5_one_start", 32'(starts - s0), 32'd1);
      check("t5_no_done", 32'(dones - d0), 32'd0);
      check("t5_no_err", 32'(errs - e0), 32'd0);
      model_en = 1'b1;

      // T6: asynchronous reset in WAIT, then a fresh job
      issue_job(0, 4, 2, 3, 1);
      tick();
      check("t6_in_wait", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_ready", 32'(job_ready), 32'd1);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_cfg", 32'({cnt_sel, cnt_addr_start, cnt_addr_end}), 32'd0);
      check("t6_rst_start", 32'(cnt_start), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      win_q.delete(); ev0 = dones + errs; d0 = dones;
      issue_job(10, 3, 2, 5, 1);
      wait_end("t6_end", ev0, 100);
      check("t6_nwin", 32'(win_q.size()), 32'd2);
      chk_win("t6_w0", 0, 5, 10, 12);
      chk_win("t6_w1", 1, 5, 13, 15);
      check("t6_done", 32'(dones - d0), 32'd1);

      check("no_back_to_back", 32'(bb_viol), 32'd0);
      check("cfg_held", 32'(hold_viol), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
